cr_huf_comp_bit_packer: RTL and testbench
=========================================

Name: cr_huf_comp_bit_packer

Overview:
Drain stage directly downstream of the Huffman-compressor codeword FIFO. It pops one entry per cycle through the FIFO's combinational read interface (empty/rdata/ren), appends each variable-length codeword LSB-first to a bit accumulator, and emits packed 64-bit words on a valid/ready stream. On an entry tagged last it flushes the partial word with a byte count, then starts the next frame.

Parameters:
IN_WIDTH, 56, FIFO entry width: [55]=last, [54:49]=len, [48:0]=code
CODE_W, 49, maximum codeword length in bits
OUT_WIDTH, 64, packed output word width

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO has no readable entry
fifo_rdata  input  56  head entry; valid whenever fifo_empty=0
fifo_ren  output  1  pop head entry this cycle (combinational)
clear  input  1  synchronous abort of the current frame
out_valid  output  1  out_data beat valid
out_ready  input  1  downstream accepts beat
out_data  output  64  packed bits; bit 0 is the oldest bit
out_last  output  1  final beat of the frame
out_bytes  output  4  valid bytes in the beat, 0..8
err_len  output  1  sticky flag: an entry with len>49 was seen

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- State: acc[127:0], fill[6:0] (0..112), state in {RUN, FLUSH}, err_len.
- Reset: acc=0, fill=0, state=RUN, err_len=0. Outputs at reset: out_valid=0, out_last=0, out_bytes=0, out_data=0, fifo_ren=0.
- Pop rule: fifo_ren = (state==RUN) && !fifo_empty && (fill<64) && !clear.
- On a pop, eff_len = min(len,49); if len>49, err_len<=1.
  - Append: acc |= (code & mask(eff_len)) << fill_after_fire.
  - fill_next = fill - 64*out_fire + eff_len.
  - If last=1, state<=FLUSH.
- Output in RUN: out_valid = fill>=64; out_data = acc[63:0]; out_bytes=8; out_last=0.
- out_fire = out_valid && out_ready. On out_fire: acc shifts right by 64 and fill decreases by 64.
- A pop can occur only when fill<64, so in RUN a pop and a fire never coincide. acc[63:0] is stable while out_valid=1 and out_ready=0.
- FLUSH: no pops.
  - fill>64: beat is 64 bits, out_last=0, out_bytes=8.
  - fill==64: beat has out_last=1, out_bytes=8.
  - 0<fill<64: beat has out_last=1, out_bytes=ceil(fill/8); bits at and above fill are 0.
  - fill==0 on entering FLUSH: one beat with out_data=0, out_bytes=0, out_last=1.
  - Firing a last beat sets acc=0, fill=0, state=RUN.
- Latency: a popped entry is visible at the outputs the cycle after the pop. Sustained throughput is one entry per cycle while fill<64.
- clear=1 (synchronous): acc=0, fill=0, state=RUN, err_len=0, fifo_ren=0 that cycle; an unfired beat is dropped. clear overrides pop and fire.
- Asynchronous reset mid-frame immediately forces all outputs to their reset values; partial data is lost.
- Every combinational output is derived from registered state plus fifo_empty/out_ready/clear; there is no rdata-to-out_data combinational path.

Test Plan:
- Entries {len=32, code=0xDEADBEEF}, then {last, len=32, code=0x01234567} -> one beat out_data=0x01234567DEADBEEF, out_last=1, out_bytes=8; no other beat.
- Three entries of len=40 with code=all-ones, third last -> beat1 is all ones with out_last=0, out_bytes=8; beat2 carries 56 ones in bits 0..55 with zeros above, out_last=1, out_bytes=7.
- Hold out_ready=0 for 10 cycles with fill>=64 and FIFO non-empty -> out_data stable, fifo_ren=0 throughout; the beat fires on the first cycle out_ready=1.
- Single entry {last, len=0} at fill=0 -> one beat with out_data=0, out_bytes=0, out_last=1; state returns to RUN.
- Entry with len=60, code=all-ones, last -> err_len=1 and stays 1; beat bits 0..48 are ones, out_bytes=7, out_last=1.
- Assert rst_n low mid-FLUSH, and separately pulse clear with fill=80 -> outputs return to reset values (clear also drops err_len); the next frame packs from bit 0.

Source files
------------

// File: rtl/cr_huf_comp_bit_packer.sv
// Huffman codeword bit packer: pops codewords from the upstream FIFO, packs them LSB-first
// into 64-bit beats on a valid/ready stream, and flushes a partial beat with a byte count on frame end.
module cr_huf_comp_bit_packer #(
   parameter int IN_WIDTH  = 56,
   parameter int CODE_W    = 49,
   parameter int OUT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fifo_empty,
   input  logic [IN_WIDTH-1:0]  fifo_rdata,
   output logic                 fifo_ren,
   input  logic                 clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last,
   output logic [3:0]           out_bytes,
   output logic                 err_len
);

   localparam int LEN_W  = IN_WIDTH - 1 - CODE_W;
   localparam int ACC_W  = 2 * OUT_WIDTH;
   localparam int FILL_W = $clog2(ACC_W);

   localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(OUT_WIDTH);
   localparam logic [3:0]        FULL_BYTES = 4'(OUT_WIDTH / 8);

   typedef enum logic {
      RUN,
      FLUSH
   } state_t;

   state_t              state, state_n;
   logic [ACC_W-1:0]    acc, acc_n;
   logic [FILL_W-1:0]   fill, fill_n;
   logic                err_n;

   logic                in_last;
   logic [LEN_W-1:0]    in_len;
   logic [CODE_W-1:0]   in_code;
   logic                len_over;
   logic [LEN_W-1:0]    eff_len;
   logic [CODE_W-1:0]   code_masked;
   logic [FILL_W-1:0]   fill_round;
   logic                out_fire;

   // Decode the head entry; overlong lengths are clamped to the widest legal codeword.
   always_comb begin
      in_last     = fifo_rdata[IN_WIDTH-1];
      in_len      = fifo_rdata[IN_WIDTH-2 -: LEN_W];
      in_code     = fifo_rdata[CODE_W-1:0];
      len_over    = in_len > LEN_W'(CODE_W);
      eff_len     = len_over ? LEN_W'(CODE_W) : in_len;
      code_masked = in_code & ~({CODE_W{1'b1}} << eff_len);
   end

   // Outputs come only from registered state plus the handshake/control inputs,
   // so there is never a path from fifo_rdata to out_data.
   always_comb begin
      fifo_ren   = (state == RUN) && !fifo_empty && (fill < WORD_BITS) && !clear;
      out_valid  = (state == FLUSH) || (fill >= WORD_BITS);
      out_data   = acc[OUT_WIDTH-1:0];
      out_last   = (state == FLUSH) && (fill <= WORD_BITS);
      fill_round = fill + FILL_W'(7);
      out_bytes  = 4'd0;
      if (out_valid) begin
         if (fill >= WORD_BITS) out_bytes = FULL_BYTES;
         else                   out_bytes = fill_round[3 +: 4];
      end
      out_fire   = out_valid && out_ready && !clear;
   end

   // NOTE: every next-state variable is defaulted to its current value first so
   // no path through this block can leave one unassigned and infer a latch.
   always_comb begin
      state_n = state;
      acc_n   = acc;
      fill_n  = fill;
      err_n   = err_len;
      if (clear) begin
         state_n = RUN;
         acc_n   = '0;
         fill_n  = '0;
         err_n   = 1'b0;
      end else begin
         if (out_fire) begin
            if (out_last) begin
               state_n = RUN;
               acc_n   = '0;
               fill_n  = '0;
            end else begin
               acc_n  = acc >> OUT_WIDTH;
               fill_n = fill - WORD_BITS;
            end
         end
         // Append lands above whatever remains after a same-cycle fire.
         if (fifo_ren) begin
            acc_n  = acc_n | (ACC_W'(code_masked) << fill_n);
            fill_n = fill_n + FILL_W'(eff_len);
            if (in_last)  state_n = FLUSH;
            if (len_over) err_n   = 1'b1;
         end
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         acc     <= '0;
         fill    <= '0;
         err_len <= 1'b0;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         fill    <= fill_n;
         err_len <= err_n;
      end
   end

endmodule

// File: tb/tb_cr_huf_comp_bit_packer.sv
// Directed bench for cr_huf_comp_bit_packer: a queue models the upstream FIFO, fired
// beats are collected and compared against hand-computed packings.
module tb_cr_huf_comp_bit_packer;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic [3:0]  bytes;
   } beat_t;

   localparam logic [48:0] ONES49 = 49'h1_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fifo_empty;
   logic [55:0] fifo_rdata;
   logic        fifo_ren;
   logic        clear;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;
   logic [3:0]  out_bytes;
   logic        err_len;

   logic [55:0] fifo_q[$];
   beat_t       beats[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   cr_huf_comp_bit_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_ren   (fifo_ren),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_bytes  (out_bytes),
      .err_len    (err_len)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [55:0] mk(input logic last, input logic [5:0] len, input logic [48:0] code);
      return {last, len, code};
   endfunction

   function automatic beat_t get_beat(input int i);
      beat_t b;
      b = '0;
      if (i < beats.size()) b = beats[i];
      return b;
   endfunction

   task automatic drive_fifo();
      fifo_empty = (fifo_q.size() == 0);
      fifo_rdata = fifo_empty ? 56'd0 : fifo_q[0];
   endtask

   task automatic push(input logic [55:0] e);
      fifo_q.push_back(e);
      drive_fifo();
   endtask

   // Called at posedge+2; samples mid-cycle, returns at posedge+2 of the next cycle.
   task automatic tick();
      logic  ren_s;
      beat_t b;
      #4;
      ren_s = fifo_ren;
      if (rst_n && !clear && out_valid && out_ready) begin
         b.data  = out_data;
         b.last  = out_last;
         b.bytes = out_bytes;
         beats.push_back(b);
      end
      @(posedge clk);
      #1;
      if (ren_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
      #1;
   endtask

   task automatic wait_beats(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && beats.size() < n; i++) tick();
      check(tag, 128'(beats.size()), 128'(n));
   endtask

   task automatic check_beat(input string tag, input int i, input logic [63:0] data,
                             input logic last, input logic [3:0] bytes);
      beat_t b;
      b = get_beat(i);
      check({tag, "_data"},  128'(b.data),  128'(data));
      check({tag, "_last"},  128'(b.last),  128'(last));
      check({tag, "_bytes"}, 128'(b.bytes), 128'(bytes));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 128'(out_valid), 128'(0));
      check({tag, "_data"},  128'(out_data),  128'(0));
      check({tag, "_last"},  128'(out_last),  128'(0));
      check({tag, "_bytes"}, 128'(out_bytes), 128'(0));
   endtask

   initial begin
      rst_n      = 1'b0;
      clear      = 1'b0;
      out_ready  = 1'b0;
      fifo_empty = 1'b1;
      fifo_rdata = '0;
      #3;
      check_idle("rst");
      check("rst_ren", 128'(fifo_ren), 128'(0));
      check("rst_err", 128'(err_len), 128'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;

      // Two 32-bit codes fill exactly one beat, which is also the frame's last.
      out_ready = 1'b1;
      beats.delete();
      push(mk(1'b0, 6'd32, 49'hDEAD_BEEF));
      push(mk(1'b1, 6'd32, 49'h0123_4567));
      wait_beats("t1_count", 1, 20);
      check_beat("t1_b0", 0, 64'h0123_4567_DEAD_BEEF, 1'b1, 4'd8);
      repeat (4) tick();
      check("t1_no_extra", 128'(beats.size()), 128'(1));
      check("t1_idle_valid", 128'(out_valid), 128'(0));

      // 3 x 40 ones: a full beat, then 56 ones flushed as 7 bytes.
      beats.delete();
      push(mk(1'b0, 6'd40, ONES49));
      push(mk(1'b0, 6'd40, ONES49));
      push(mk(1'b1, 6'd40, ONES49));
      wait_beats("t2_count", 2, 20);
      check_beat("t2_b0", 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd8);
      check_beat("t2_b1", 1, 64'h00FF_FFFF_FFFF_FFFF, 1'b1, 4'd7);

      // Backpressure: beat held stable, no pops while fill>=64.
      out_ready = 1'b0;
      beats.delete();
      push(mk(1'b0, 6'd40, ONES49));
      push(mk(1'b0, 6'd40, ONES49));
      push(mk(1'b1, 6'd40, ONES49));
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         check("t3_hold_valid", 128'(out_valid), 128'(1));
         check("t3_hold_data", 128'(out_data), 128'(64'hFFFF_FFFF_FFFF_FFFF));
         check("t3_hold_ren", 128'(fifo_ren), 128'(0));
         tick();
      end
      check("t3_no_beat", 128'(beats.size()), 128'(0));
      out_ready = 1'b1;
      tick();
      check("t3_first_fire", 128'(beats.size()), 128'(1));
      wait_beats("t3_count", 2, 20);
      check_beat("t3_b0", 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd8);
      check_beat("t3_b1", 1, 64'h00FF_FFFF_FFFF_FFFF, 1'b1, 4'd7);

      // Empty frame: zero-length last entry yields a zero-byte last beat.
      beats.delete();
      push(mk(1'b1, 6'd0, 49'h1234));
      wait_beats("t4_count", 1, 20);
      check_beat("t4_b0", 0, 64'd0, 1'b1, 4'd0);
      tick();
      check("t4_back_run", 128'(out_valid), 128'(0));
      check("t4_err", 128'(err_len), 128'(0));

      // Overlong length clamps to 49 bits and sets the sticky error.
      beats.delete();
      push(mk(1'b1, 6'd60, ONES49));
      wait_beats("t5_count", 1, 20);
      check_beat("t5_b0", 0, 64'h0001_FFFF_FFFF_FFFF, 1'b1, 4'd7);
      check("t5_err", 128'(err_len), 128'(1));
      repeat (3) tick();
      check("t5_err_sticky", 128'(err_len), 128'(1));

      // Asynchronous reset while a flush beat is stalled.
      out_ready = 1'b0;
      beats.delete();
      push(mk(1'b1, 6'd20, 49'hA_BCDE));
      tick();
      check("t6_flush_valid", 128'(out_valid), 128'(1));
      check("t6_flush_last", 128'(out_last), 128'(1));
      check("t6_flush_bytes", 128'(out_bytes), 128'(3));
      rst_n = 1'b0;
      #1;
      check_idle("t6_rst");
      check("t6_rst_err", 128'(err_len), 128'(0));
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      push(mk(1'b1, 6'd8, 49'hA5));
      wait_beats("t6_count", 1, 20);
      check_beat("t6_b0", 0, 64'hA5, 1'b1, 4'd1);

      // Synchronous clear at fill=80 drops the beat and err_len, then the next frame starts at bit 0.
      out_ready = 1'b0;
      beats.delete();
      push(mk(1'b0, 6'd60, ONES49));
      push(mk(1'b0, 6'd31, 49'h7FFF_FFFF));
      push(mk(1'b1, 6'd4, 49'h9));
      tick();
      tick();
      check("t7_pre_valid", 128'(out_valid), 128'(1));
      check("t7_pre_err", 128'(err_len), 128'(1));
      clear = 1'b1;
      out_ready = 1'b1;
      tick();
      check("t7_clear_ren", 128'(fifo_ren), 128'(0));
      check("t7_clear_valid", 128'(out_valid), 128'(0));
      tick();
      clear = 1'b0;
      #1;
      check_idle("t7_post");
      check("t7_post_err", 128'(err_len), 128'(0));
      check("t7_post_ren", 128'(fifo_ren), 128'(1));
      wait_beats("t7_count", 1, 20);
      check_beat("t7_b0", 0, 64'h9, 1'b1, 4'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
